// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: default bus widths, reset PC and instruction size.
package cpu_pkg;
  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned WORD_WIDTH_DEF = 32;
  localparam int unsigned RESET_PC_DEF   = 0;
  localparam int unsigned INSTR_BYTES    = 4;
endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between the ROM response and decode.
module fetch_skid_buf #(
  parameter int unsigned DW = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] push_data,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);
  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // Flush wins over push/pop so a redirect never leaks a stale entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the synchronous ROM and hands {pc, instr} to decode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WORD_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [WORD_WIDTH-1:0] out_instr
);
  localparam int unsigned DW = ADDR_WIDTH + WORD_WIDTH;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic                  req_valid_q;
  logic [1:0]            count;
  logic [DW-1:0]         head;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;

  assign pop       = out_valid && out_ready;
  // Slots already claimed next cycle: buffered + in-flight - leaving now.
  assign occupancy = 3'(count) + 3'(req_valid_q) - 3'(pop);
  assign issue     = !redirect_valid && (occupancy < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc & ~ADDR_WIDTH'(3);
      req_valid_q <= 1'b0;
    end else if (issue) begin
      pc_q        <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
      req_pc_q    <= pc_q;
      req_valid_q <= 1'b1;
    end else begin
      req_valid_q <= 1'b0;
    end
  end

  fetch_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid_q),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data ({req_pc_q, rom_data}),
    .count     (count),
    .head      (head)
  );

  assign rom_addr               = pc_q;
  assign out_valid              = (count != 2'd0);
  assign {out_pc, out_instr}    = head;
endmodule
